kbd_event_ctrl: RTL and testbench
=================================

// Module: kbd_event_ctrl
// PURPOSE
//   Sequences the PS/2 byte receiver (ps2_keyboard): pops raw scan-code bytes via its
//   nextdata_n handshake, folds E0/F0 prefixes into make/break events, tracks modifier
//   state (shift, ctrl, caps lock), and buffers the events in a FIFO that the CPU-side
//   MMIO reader drains. Sits between ps2_keyboard and the keyboard MMIO register block.
// PARAMETERS
//   DEPTH        16  event FIFO entries; power of two, >= 2
//   SUPPRESS_REP 1   1 = drop typematic repeat makes of the key already held
// PORTS
//   clk          in   1   system clock
//   clrn         in   1   asynchronous active-low reset
//   rx_data      in   8   byte from ps2_keyboard (valid while rx_ready=1)
//   rx_ready     in   1   ps2_keyboard has an unread byte
//   rx_overflow  in   1   ps2_keyboard internal FIFO overflowed
//   rx_nextdata_n out 1   low for one cycle = pop current byte from ps2_keyboard
//   evt_data     out  16  FIFO head: {ext,brk,lshift|rshift,ctrl,caps,3'b0,code[7:0]}
//   evt_valid    out  1   FIFO non-empty
//   evt_rd       in   1   pop head (ignored when evt_valid=0)
//   evt_count    out  $clog2(DEPTH)+1  entries in FIFO
//   mod_shift    out  1   either shift held;  mod_ctrl out 1 ctrl held;  mod_caps out 1
//   status       out  2   sticky {rx_lost, evt_lost}
//   status_clr   in   1   clears status (set events in the same cycle win)
// BEHAVIOUR
//   Reset (clrn=0, async): rx_nextdata_n=1, FIFO empty (evt_valid=0, evt_count=0,
//     evt_data=0), modifiers 0, prefix=NONE, last_make=0, status=0. Mid-operation reset
//     discards any half-decoded prefix and all queued events.
//   Fetch FSM: WAIT (nextdata_n=1; rx_ready=1 -> latch rx_data, go ACK) -> ACK
//     (nextdata_n=0 one cycle; decode latched byte) -> GAP (nextdata_n=1 one cycle so
//     rx_ready can update) -> WAIT. Max one byte per 3 cycles; never two ACK cycles back to back.
//   Prefix FSM (advances in ACK): NONE: E0->E0, F0->F0, else make(ext=0).
//     E0: F0->E0F0, E0->E0, else make(ext=1). F0: break(ext=0)->NONE.
//     E0F0: break(ext=1)->NONE. Any byte AA/FA/FE/EE/00/FF in NONE: discarded, no event.
//   Modifiers: code 12 -> lshift, 59 -> rshift, 14 -> ctrl (ext 0 or 1); make sets, break
//     clears. Caps: non-repeat make of 58 toggles mod_caps; break of 58 no effect.
//   Event fields use modifier values AFTER the current event updates them.
//   Repeat: make with {ext,code} == last_make and SUPPRESS_REP=1 -> no push, no caps
//     toggle. Make updates last_make; break of last_make clears it to 0.
//   Latency: rx_ready seen in WAIT at cycle t -> push at end of t+1 -> evt_valid at t+2.
//   FIFO: first-word-fall-through; evt_data = head when evt_valid, else 0. Pop on
//     evt_rd&evt_valid. Push when full and no pop -> event dropped, status[0] set.
//     Push and pop same cycle when full -> both happen, count unchanged. Pointers wrap
//     mod DEPTH; count in 0..DEPTH.
//   rx_overflow=1 in any cycle sets status[1]. status_clr clears both bits unless a
//     set event occurs that cycle.
// TESTING
//   Bytes 1C, F0,1C (rx_ready handshake) -> events 001C (make) then 401C (brk); nextdata_n low exactly 3 cycles total.
//   12, 1C, F0 1C, F0 12 -> 0012|shift=2000 form: 2012, 201C, 601C, 4012; mod_shift ends 0.
//   58, F0 58, 58 -> mod_caps 1,1,0; events 0858, 4858, 0058.
//   E0 75, E0 F0 75 -> 8075 then C075; 1C,1C,1C with SUPPRESS_REP=1 -> single 001C.
//   DEPTH+2 makes of distinct codes, no evt_rd -> count=DEPTH, status=01; then
//     status_clr -> 00; pop all in order -> evt_valid 0, evt_data 0.
//   Assert clrn low between E0 and 75 -> after release, 75 yields 0075 (ext=0), FIFO empty before it.

Source files
------------

// File: rtl/kbd_event_ctrl.sv
// Keyboard event sequencer: pops scan-code bytes from ps2_keyboard, folds E0/F0 prefixes
// into make/break events with modifier snapshots, and queues them in a FWFT FIFO.
module kbd_event_ctrl #(
  parameter int DEPTH        = 16,
  parameter int SUPPRESS_REP = 1
) (
  input  logic                     clk,
  input  logic                     clrn,
  input  logic [7:0]               rx_data,
  input  logic                     rx_ready,
  input  logic                     rx_overflow,
  output logic                     rx_nextdata_n,
  output logic [15:0]              evt_data,
  output logic                     evt_valid,
  input  logic                     evt_rd,
  output logic [$clog2(DEPTH):0]   evt_count,
  output logic                     mod_shift,
  output logic                     mod_ctrl,
  output logic                     mod_caps,
  output logic [1:0]               status,
  input  logic                     status_clr,
  output logic [1:0]               fetch_state_dbg,
  output logic [1:0]               prefix_state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Handshake: a byte is offered while rx_ready=1 and is consumed by the one-cycle
  // low pulse on rx_nextdata_n (ACK); the following GAP cycle lets rx_ready refresh.
  typedef enum logic [1:0] {F_WAIT = 2'd0, F_ACK = 2'd1, F_GAP = 2'd2} fetch_t;
  typedef enum logic [1:0] {P_NONE = 2'd0, P_E0 = 2'd1, P_F0 = 2'd2, P_E0F0 = 2'd3} prefix_t;

  fetch_t  f_state, f_next;
  prefix_t p_state, p_next;

  logic [7:0]    byte_q;
  logic          lshift, rshift, ctrl, caps;
  logic          lshift_n, rshift_n, ctrl_n, caps_n;
  logic [8:0]    last_make, last_make_n;
  logic          ev_hit, ev_ext, ev_brk, is_rep, is_junk, push;
  logic [15:0]   push_data;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, pop, do_push, drop;
  logic [1:0]    status_q;

  // Fetch FSM
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      f_state <= F_WAIT;
      byte_q  <= 8'h00;
    end else begin
      f_state <= f_next;
      if (f_state == F_WAIT && rx_ready) byte_q <= rx_data;
    end
  end

  always_comb begin
    f_next        = f_state;
    rx_nextdata_n = 1'b1;
    case (f_state)
      F_WAIT:  if (rx_ready) f_next = F_ACK;
      F_ACK: begin
        rx_nextdata_n = 1'b0;
        f_next        = F_GAP;
      end
      F_GAP:   f_next = F_WAIT;
      default: f_next = F_WAIT;
    endcase
  end

  // Prefix FSM, advanced only while the latched byte is being acknowledged
  assign is_junk = byte_q inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};

  always_comb begin
    p_next = p_state;
    ev_hit = 1'b0;
    ev_ext = 1'b0;
    ev_brk = 1'b0;
    if (f_state == F_ACK) begin
      case (p_state)
        P_NONE: begin
          if (byte_q == 8'hE0)      p_next = P_E0;
          else if (byte_q == 8'hF0) p_next = P_F0;
          else if (!is_junk)        ev_hit = 1'b1;
        end
        P_E0: begin
          if (byte_q == 8'hF0)      p_next = P_E0F0;
          else if (byte_q == 8'hE0) p_next = P_E0;
          else begin
            ev_hit = 1'b1;
            ev_ext = 1'b1;
            p_next = P_NONE;
          end
        end
        P_F0: begin
          ev_hit = 1'b1;
          ev_brk = 1'b1;
          p_next = P_NONE;
        end
        default: begin
          ev_hit = 1'b1;
          ev_ext = 1'b1;
          ev_brk = 1'b1;
          p_next = P_NONE;
        end
      endcase
    end
  end

  // Modifier / repeat tracking; event fields carry the post-update modifier values
  always_comb begin
    lshift_n    = lshift;
    rshift_n    = rshift;
    ctrl_n      = ctrl;
    caps_n      = caps;
    last_make_n = last_make;
    is_rep      = ev_hit && !ev_brk && (SUPPRESS_REP != 0) && ({ev_ext, byte_q} == last_make);
    if (ev_hit) begin
      if (byte_q == 8'h12) lshift_n = !ev_brk;
      if (byte_q == 8'h59) rshift_n = !ev_brk;
      if (byte_q == 8'h14) ctrl_n   = !ev_brk;
      if (byte_q == 8'h58 && !ev_brk && !is_rep) caps_n = !caps;
      if (!ev_brk)                                last_make_n = {ev_ext, byte_q};
      else if ({ev_ext, byte_q} == last_make)     last_make_n = 9'h000;
    end
    push      = ev_hit && !is_rep;
    push_data = {ev_ext, ev_brk, lshift_n | rshift_n, ctrl_n, caps_n, 3'b000, byte_q};
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      p_state   <= P_NONE;
      lshift    <= 1'b0;
      rshift    <= 1'b0;
      ctrl      <= 1'b0;
      caps      <= 1'b0;
      last_make <= 9'h000;
    end else begin
      p_state   <= p_next;
      lshift    <= lshift_n;
      rshift    <= rshift_n;
      ctrl      <= ctrl_n;
      caps      <= caps_n;
      last_make <= last_make_n;
    end
  end

  // Event FIFO (first-word-fall-through); a push into a full FIFO survives only if a pop
  // frees the slot in the same cycle
  assign full    = (count == CW'(DEPTH));
  assign pop     = evt_rd && (count != '0);
  assign do_push = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      status_q <= 2'b00;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(pop);
      status_q[1] <= rx_overflow ? 1'b1 : (status_clr ? 1'b0 : status_q[1]);
      status_q[0] <= drop        ? 1'b1 : (status_clr ? 1'b0 : status_q[0]);
    end
  end

  assign evt_valid        = (count != '0);
  assign evt_data         = evt_valid ? mem[rd_ptr] : 16'h0000;
  assign evt_count        = count;
  assign mod_shift        = lshift | rshift;
  assign mod_ctrl         = ctrl;
  assign mod_caps         = caps;
  assign status           = status_q;
  assign fetch_state_dbg  = f_state;
  assign prefix_state_dbg = p_state;

endmodule

// File: tb/tb_kbd_event_ctrl.sv
// Directed bench for kbd_event_ctrl: a ps2_keyboard byte-source model, FIFO drain checks,
// modifier/caps/repeat cases, overflow/status behaviour and mid-prefix reset.
module tb_kbd_event_ctrl;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready = 1'b0;
  logic        rx_overflow = 1'b0;
  logic        rx_nextdata_n;
  logic [15:0] evt_data;
  logic        evt_valid;
  logic        evt_rd = 1'b0;
  logic [4:0]  evt_count;
  logic        mod_shift, mod_ctrl, mod_caps;
  logic [1:0]  status;
  logic        status_clr = 1'b0;
  logic [1:0]  fetch_state_dbg, prefix_state_dbg;

  int checks = 0;
  int passes = 0;
  int ack_cycles = 0;
  int ack_base;

  kbd_event_ctrl #(.DEPTH(DEPTH), .SUPPRESS_REP(1)) dut (
    .clk(clk), .clrn(clrn),
    .rx_data(rx_data), .rx_ready(rx_ready), .rx_overflow(rx_overflow),
    .rx_nextdata_n(rx_nextdata_n),
    .evt_data(evt_data), .evt_valid(evt_valid), .evt_rd(evt_rd), .evt_count(evt_count),
    .mod_shift(mod_shift), .mod_ctrl(mod_ctrl), .mod_caps(mod_caps),
    .status(status), .status_clr(status_clr),
    .fetch_state_dbg(fetch_state_dbg), .prefix_state_dbg(prefix_state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rx_nextdata_n === 1'b0) ack_cycles <= ack_cycles + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // driver: present one byte like ps2_keyboard, retire it on the ACK pulse
  task automatic send_byte(input logic [7:0] b);
    int n;
    @(negedge clk);
    rx_data  = b;
    rx_ready = 1'b1;
    n = 0;
    while (rx_nextdata_n !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("ack_timeout", 32'(n), 32'(0));
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [15:0] exp);
    @(negedge clk);
    check({tag, "_valid"}, 32'(evt_valid), 32'(1));
    check(tag, 32'(evt_data), 32'(exp));
    evt_rd = 1'b1;
    @(negedge clk);
    evt_rd = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clrn = 1'b0;
    repeat (2) @(negedge clk);
    clrn = 1'b1;
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    check("rst_nextdata_n", 32'(rx_nextdata_n), 32'(1));
    check("rst_evt_valid", 32'(evt_valid), 32'(0));
    check("rst_evt_count", 32'(evt_count), 32'(0));
    check("rst_evt_data", 32'(evt_data), 32'(0));
    check("rst_status", 32'(status), 32'(0));
    check("rst_mods", 32'({mod_shift, mod_ctrl, mod_caps}), 32'(0));
    check("rst_fetch_state", 32'(fetch_state_dbg), 32'(0));
    clrn = 1'b1;

    // make / break, three ACK pulses in total
    ack_base = ack_cycles;
    send_byte(8'h1C);
    check("lat_first_valid", 32'(evt_count), 32'(1));
    send_byte(8'hF0);
    send_byte(8'h1C);
    repeat (2) @(negedge clk);
    check("mb_ack_cycles", 32'(ack_cycles - ack_base), 32'(3));
    check("mb_count", 32'(evt_count), 32'(2));
    pop_expect("mb_make", 16'h001C);
    pop_expect("mb_break", 16'h401C);
    check("mb_empty", 32'(evt_valid), 32'(0));

    // shift snapshots
    send_byte(8'h12);
    check("shift_held", 32'(mod_shift), 32'(1));
    send_byte(8'h1C);
    send_byte(8'hF0); send_byte(8'h1C);
    send_byte(8'hF0); send_byte(8'h12);
    check("shift_released", 32'(mod_shift), 32'(0));
    pop_expect("sh_make12", 16'h2012);
    pop_expect("sh_make1c", 16'h201C);
    pop_expect("sh_brk1c", 16'h601C);
    pop_expect("sh_brk12", 16'h4012);

    // ctrl modifier, extended variant
    send_byte(8'hE0); send_byte(8'h14);
    check("ctrl_held", 32'(mod_ctrl), 32'(1));
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h14);
    check("ctrl_released", 32'(mod_ctrl), 32'(0));
    pop_expect("ctrl_make", 16'h9014);
    pop_expect("ctrl_brk", 16'hC014);

    // caps lock toggling
    send_byte(8'h58);
    check("caps_1", 32'(mod_caps), 32'(1));
    send_byte(8'hF0); send_byte(8'h58);
    check("caps_2", 32'(mod_caps), 32'(1));
    send_byte(8'h58);
    check("caps_3", 32'(mod_caps), 32'(0));
    pop_expect("caps_ev1", 16'h0858);
    pop_expect("caps_ev2", 16'h4858);
    pop_expect("caps_ev3", 16'h0058);

    // extended keys, repeat suppression, discarded bytes
    send_byte(8'hE0); send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    pop_expect("ext_make", 16'h8075);
    pop_expect("ext_brk", 16'hC075);
    send_byte(8'h1C); send_byte(8'h1C); send_byte(8'h1C);
    send_byte(8'hAA); send_byte(8'hFA);
    check("rep_count", 32'(evt_count), 32'(1));
    pop_expect("rep_single", 16'h001C);
    check("rep_empty", 32'(evt_valid), 32'(0));

    // fill past capacity
    for (int i = 0; i < DEPTH + 2; i++) send_byte(8'(8'h20 + i));
    check("full_count", 32'(evt_count), 32'(DEPTH));
    check("full_status", 32'(status), 32'(2'b01));
    @(negedge clk); status_clr = 1'b1;
    @(negedge clk); status_clr = 1'b0;
    check("clr_status", 32'(status), 32'(0));
    for (int i = 0; i < DEPTH; i++) pop_expect("drain", 16'(16'h0020 + i));
    check("drain_valid", 32'(evt_valid), 32'(0));
    check("drain_data", 32'(evt_data), 32'(0));
    check("drain_count", 32'(evt_count), 32'(0));

    // rx overflow is sticky and wins over a same-cycle clear
    @(negedge clk); rx_overflow = 1'b1;
    @(negedge clk); rx_overflow = 1'b0;
    check("ovf_set", 32'(status), 32'(2'b10));
    rx_overflow = 1'b1; status_clr = 1'b1;
    @(negedge clk); rx_overflow = 1'b0;
    check("ovf_set_wins", 32'(status), 32'(2'b10));
    @(negedge clk); status_clr = 1'b0;
    check("ovf_cleared", 32'(status), 32'(0));

    // reset between prefix and code
    send_byte(8'h1C);
    send_byte(8'hE0);
    do_reset();
    check("mid_rst_valid", 32'(evt_valid), 32'(0));
    check("mid_rst_prefix", 32'(prefix_state_dbg), 32'(0));
    send_byte(8'h75);
    check("post_rst_count", 32'(evt_count), 32'(1));
    pop_expect("post_rst_75", 16'h0075);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("%0d/%0d checks passed", passes, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
